char_bitmap_decoder: RTL and testbench
======================================

Name: char_bitmap_decoder

Overview:
- Recovers the 25-bit 5x5 character bitmap from the rendered RGB pixel stream on the 9 MHz LCD path.
- Reads the same vgaCount/lineCount counters and RGB bus that the character renderer drives.
- Returns the bitmap that was actually displayed, plus a consistency flag.
- Used for on-chip self-check and loopback of the character display path.

Parameters:
PIPE_DELAY, 1, cycles between a counter value and the RGB pixel it produces (renderer output register); range 0..3
CONTINUOUS, 0, 1 = re-arm automatically after each completed frame

Ports:
clk9MHz  input  1  pixel clock
reset  input  1  synchronous, active-high reset
arm  input  1  request capture of the next full frame (level or pulse)
vgaCount  input  10  horizontal pixel counter
lineCount  input  9  vertical line counter
redPixels  input  8  red channel of rendered pixel
greenPixels  input  8  green channel
bluePixels  input  8  blue channel
characterPixels  output  25  recovered bitmap; bit 24 = row0/col0, bit 0 = row4/col4
valid  output  1  one-cycle pulse when characterPixels is updated
busy  output  1  high in WAIT_FRAME or CAPTURE
error  output  1  inconsistency flag for the last completed frame; held until next completion

Behaviour:
- Reset: characterPixels=0, valid=0, busy=0, error=0, FSM=IDLE, all internal accumulators cleared. Reset wins over every other input in the same cycle.
- Counter alignment: vgaCount and lineCount are delayed PIPE_DELAY cycles (vx, ly) so each RGB sample is matched to the counters that produced it.
- Pixel class:
  - LIT: all three channels == 8'hFF.
  - DARK: all three channels == 8'h00.
  - Anything else: MIXED.
- Grid columns, on vx:
  - col0: 44..92
  - col1: 93..142
  - col2: 143..192
  - col3: 193..242
  - col4: 243..292
- Grid rows, on ly: row r covers 50r..50r+49, for r = 0..4.
- Cell bit index = 24 - (5*row + col).
- FSM:
  - IDLE: busy=0. Goes to WAIT_FRAME when arm=1.
  - WAIT_FRAME: busy=1. Clears the seen[24:0], val[24:0] and err accumulators. Goes to CAPTURE on the cycle where vx==0 and ly==0; that cycle's pixel is processed in CAPTURE rules.
  - CAPTURE, each cycle:
    - Pixel inside a cell, first pixel of that cell (seen=0): val[bit]=LIT, seen[bit]=1.
    - Pixel inside a cell, later pixel: class differs from val[bit], or is MIXED, sets err.
    - Pixel outside the grid that is not DARK sets err.
    - A MIXED pixel always sets err.
    - Exits to DONE when ly reaches 250.
    - Also exits to DONE, with err forced to 1, when ly goes back to 0 before reaching 250 (short frame).
  - DONE (single cycle):
    - characterPixels <= val.
    - error <= err | ~&seen, so any unvisited cell is an error.
    - valid=1 for this cycle only.
    - Next state is WAIT_FRAME if CONTINUOUS=1 or arm=1, otherwise IDLE.
- Latency: valid asserts PIPE_DELAY+1 cycles after the raw lineCount first equals 250.
- arm while busy is ignored; it causes no restart.
- characterPixels and error are unchanged outside DONE.
- Lines 250..271 and columns outside 44..292 contribute only the outside-grid check.
- Reset asserted mid-CAPTURE aborts the capture: no valid pulse, outputs return to their reset values.

Test Plan:
- Reset for 2 cycles, then idle 1000 cycles with arm=0 -> characterPixels=0, valid=0, busy=0, error=0.
- Behavioural renderer (registered RGB, PIPE_DELAY=1) drives 25'h1555555; arm at lineCount=260 -> busy until frame end, exactly one valid pulse after lineCount 250 of the next frame, characterPixels=25'h1555555, error=0.
- Back-to-back frames 25'h1FFFFFF then 25'h0000000 with CONTINUOUS=1 -> two valid pulses with those values, error=0 on both.
- Bitmap 25'h0F0F0F0 with greenPixels forced to 8'h80 at vgaCount=150, lineCount=120 -> characterPixels=25'h0F0F0F0, error=1.
- Bitmap 25'h1000001 with one white pixel injected at vgaCount=10, lineCount=5 -> error=1. Next clean frame -> error=0.
- Reset pulsed at lineCount=120 during CAPTURE -> no valid, outputs 0. Re-arm -> next frame captured correctly.
- PIPE_DELAY=0 run with a combinational renderer model on 25'h1555555 -> same result as the PIPE_DELAY=1 case.

Source files
------------

// File: rtl/char_bitmap_decoder.sv
// Recovers the 5x5 character bitmap from the rendered RGB stream and flags any
// frame whose pixels are inconsistent with a clean two-colour glyph.
module char_bitmap_decoder #(
  parameter int PIPE_DELAY = 1,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic        clk9MHz,
  input  logic        reset,
  input  logic        arm,
  input  logic [9:0]  vgaCount,
  input  logic [8:0]  lineCount,
  input  logic [7:0]  redPixels,
  input  logic [7:0]  greenPixels,
  input  logic [7:0]  bluePixels,
  output logic [24:0] characterPixels,
  output logic        valid,
  output logic        busy,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, WAIT_FRAME, CAPTURE, DONE} state_t;
  state_t state;

  logic [9:0] vx;
  logic [8:0] ly;

  // Counters are lined up with the renderer's output register latency.
  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign vx = vgaCount;
      assign ly = lineCount;
    end else begin : g_dly
      logic [PIPE_DELAY-1:0][9:0] vx_pipe;
      logic [PIPE_DELAY-1:0][8:0] ly_pipe;
      always_ff @(posedge clk9MHz) begin
        if (reset) begin
          vx_pipe <= '0;
          ly_pipe <= '0;
        end else begin
          vx_pipe[0] <= vgaCount;
          ly_pipe[0] <= lineCount;
          for (int i = 1; i < PIPE_DELAY; i++) begin
            vx_pipe[i] <= vx_pipe[i-1];
            ly_pipe[i] <= ly_pipe[i-1];
          end
        end
      end
      assign vx = vx_pipe[PIPE_DELAY-1];
      assign ly = ly_pipe[PIPE_DELAY-1];
    end
  endgenerate

  logic        lit, dark, mixed, in_cell, frame_end, short_frame;
  logic [2:0]  col, row;
  logic [4:0]  cbit;
  logic [24:0] seen, val, seen_b, val_b, seen_n, val_n;
  logic        err, err_b, err_n;
  logic [8:0]  ly_last;

  always_comb begin
    lit   = (redPixels == 8'hFF) && (greenPixels == 8'hFF) && (bluePixels == 8'hFF);
    dark  = (redPixels == 8'h00) && (greenPixels == 8'h00) && (bluePixels == 8'h00);
    mixed = !lit && !dark;

    col = 3'd5;
    if      (vx >= 10'd44  && vx <= 10'd92)  col = 3'd0;
    else if (vx >= 10'd93  && vx <= 10'd142) col = 3'd1;
    else if (vx >= 10'd143 && vx <= 10'd192) col = 3'd2;
    else if (vx >= 10'd193 && vx <= 10'd242) col = 3'd3;
    else if (vx >= 10'd243 && vx <= 10'd292) col = 3'd4;

    row = 3'd5;
    if      (ly <= 9'd49)  row = 3'd0;
    else if (ly <= 9'd99)  row = 3'd1;
    else if (ly <= 9'd149) row = 3'd2;
    else if (ly <= 9'd199) row = 3'd3;
    else if (ly <= 9'd249) row = 3'd4;

    in_cell = (col < 3'd5) && (row < 3'd5);
    cbit    = 5'(24 - (5 * int'(row) + int'(col)));

    // The frame-start pixel is judged against freshly cleared accumulators.
    seen_b = (state == CAPTURE) ? seen : '0;
    val_b  = (state == CAPTURE) ? val  : '0;
    err_b  = (state == CAPTURE) ? err  : 1'b0;

    seen_n = seen_b;
    val_n  = val_b;
    err_n  = err_b;
    if (in_cell) begin
      if (!seen_b[cbit]) begin
        seen_n[cbit] = 1'b1;
        val_n[cbit]  = lit;
      end else if (lit != val_b[cbit]) begin
        err_n = 1'b1;
      end
    end else if (!dark) begin
      err_n = 1'b1;
    end
    if (mixed) err_n = 1'b1;

    frame_end   = (ly >= 9'd250);
    short_frame = (ly == 9'd0) && (ly_last != 9'd0);
  end

  always_ff @(posedge clk9MHz) begin
    if (reset) begin
      state           <= IDLE;
      seen            <= '0;
      val             <= '0;
      err             <= 1'b0;
      ly_last         <= '0;
      characterPixels <= '0;
      valid           <= 1'b0;
      busy            <= 1'b0;
      error           <= 1'b0;
    end else begin
      valid   <= 1'b0;
      ly_last <= ly;
      case (state)
        IDLE: if (arm) begin
          state <= WAIT_FRAME;
          busy  <= 1'b1;
        end
        WAIT_FRAME: begin
          seen <= '0;
          val  <= '0;
          err  <= 1'b0;
          if (vx == 10'd0 && ly == 9'd0) begin
            seen  <= seen_n;
            val   <= val_n;
            err   <= err_n;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          seen <= seen_n;
          val  <= val_n;
          err  <= err_n;
          // Results land on the exit edge so valid is high during DONE.
          if (frame_end || short_frame) begin
            characterPixels <= val_n;
            error           <= err_n | short_frame | ~&seen_n;
            valid           <= 1'b1;
            busy            <= 1'b0;
            state           <= DONE;
          end
        end
        DONE: begin
          if (CONTINUOUS || arm) begin
            state <= WAIT_FRAME;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_bitmap_decoder.sv
// Drives sparse rendered frames into three decoder configurations and checks
// captured bitmaps, error flags, latency and control behaviour.
module tb_char_bitmap_decoder;

  logic clk9MHz = 1'b0;
  always #5 clk9MHz = ~clk9MHz;

  logic        reset, arm, arm_c;
  logic [9:0]  vc;
  logic [8:0]  lc;
  logic [24:0] cur_bm;
  logic        inj_en;
  int          inj_x, inj_y;
  logic [23:0] inj_rgb, rgb_comb, rgb_reg;

  logic [24:0] bits1, bits0, bitsc;
  logic        val1, val0, valc, busy1, busy0, busyc, err1, err0, errc;

  // Sparse sample points: every cell boundary plus interior and outside points.
  int xs[20] = '{0, 10, 43, 44, 68, 92, 93, 120, 142, 143, 150, 192, 193, 220, 242, 243, 270, 292, 293, 299};
  int ys[19] = '{0, 5, 25, 49, 50, 75, 99, 100, 120, 149, 150, 175, 199, 200, 225, 249, 250, 260, 271};

  function automatic logic [23:0] pix(input logic [24:0] bm, input int x, input int y,
                                      input logic ie, input int ix, input int iy, input logic [23:0] irgb);
    int c, r;
    if (ie && x == ix && y == iy) return irgb;
    c = (x >= 44) ? (x - 43) / 50 : 5;
    r = y / 50;
    if (c < 5 && r < 5 && bm[24 - (5 * r + c)]) return 24'hFFFFFF;
    return 24'h000000;
  endfunction

  always_comb rgb_comb = pix(cur_bm, int'(vc), int'(lc), inj_en, inj_x, inj_y, inj_rgb);
  always @(posedge clk9MHz) rgb_reg <= rgb_comb;

  char_bitmap_decoder #(.PIPE_DELAY(1), .CONTINUOUS(1'b0)) dut (
    .clk9MHz(clk9MHz), .reset(reset), .arm(arm), .vgaCount(vc), .lineCount(lc),
    .redPixels(rgb_reg[23:16]), .greenPixels(rgb_reg[15:8]), .bluePixels(rgb_reg[7:0]),
    .characterPixels(bits1), .valid(val1), .busy(busy1), .error(err1));

  char_bitmap_decoder #(.PIPE_DELAY(0), .CONTINUOUS(1'b0)) dut0 (
    .clk9MHz(clk9MHz), .reset(reset), .arm(arm), .vgaCount(vc), .lineCount(lc),
    .redPixels(rgb_comb[23:16]), .greenPixels(rgb_comb[15:8]), .bluePixels(rgb_comb[7:0]),
    .characterPixels(bits0), .valid(val0), .busy(busy0), .error(err0));

  char_bitmap_decoder #(.PIPE_DELAY(1), .CONTINUOUS(1'b1)) dut_c (
    .clk9MHz(clk9MHz), .reset(reset), .arm(arm_c), .vgaCount(vc), .lineCount(lc),
    .redPixels(rgb_reg[23:16]), .greenPixels(rgb_reg[15:8]), .bluePixels(rgb_reg[7:0]),
    .characterPixels(bitsc), .valid(valc), .busy(busyc), .error(errc));

  int cyc = 0;
  always @(posedge clk9MHz) cyc <= cyc + 1;

  int          nval = 0, nval0 = 0, tv = 0, tv0 = 0;
  logic [24:0] bits_q = '0, bits0_q = '0;
  logic        err_q = 1'b0, err0_q = 1'b0;
  logic [24:0] cbits[$];
  logic        cerr[$];

  always @(negedge clk9MHz) begin
    if (val1) begin nval <= nval + 1; bits_q <= bits1; err_q <= err1; tv <= cyc; end
    if (val0) begin nval0 <= nval0 + 1; bits0_q <= bits0; err0_q <= err0; tv0 <= cyc; end
    if (valc) begin cbits.push_back(bitsc); cerr.push_back(errc); end
  end

  int nvec = 0, nbad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Set-based reference: collect the classes seen in each cell, then judge.
  function automatic void model(input logic [24:0] bm, input logic ie, input int ix, input int iy,
                                input logic [23:0] irgb, input logic shortf,
                                output logic [24:0] eb, output logic ee);
    logic [2:0] cls[25];
    logic       fl[25];
    logic       stop;
    logic [23:0] p;
    int k, c, r, idx;
    for (int n = 0; n < 25; n++) begin cls[n] = '0; fl[n] = 1'b0; end
    ee = 1'b0; eb = '0; stop = 1'b0;
    for (int j = 0; j < 19 && !stop; j++) begin
      if (shortf && ys[j] >= 200) break;
      for (int i = 0; i < 20; i++) begin
        p = pix(bm, xs[i], ys[j], ie, ix, iy, irgb);
        k = (p == 24'hFFFFFF) ? 1 : (p == 24'h0) ? 0 : 2;
        c = (xs[i] >= 44) ? (xs[i] - 43) / 50 : 5;
        r = ys[j] / 50;
        if (c < 5 && r < 5) begin
          idx = 5 * r + c;
          if (cls[idx] == 3'b000) fl[idx] = (k == 1);
          cls[idx][k] = 1'b1;
        end else if (k != 0) begin
          ee = 1'b1;
        end
        if (ys[j] >= 250) begin stop = 1'b1; break; end
      end
    end
    for (int n = 0; n < 25; n++) begin
      if (cls[n] == 3'b000 || $countones(cls[n]) > 1 || cls[n][2]) ee = 1'b1;
      eb[24 - n] = fl[n];
    end
    if (shortf) ee = 1'b1;
  endfunction

  int          t250 = 0;
  logic        busy_mid, busy_end, err_mid;
  logic [24:0] bits_mid;

  task automatic frame(input logic [24:0] bm, input logic ie, input int ix, input int iy,
                       input logic [23:0] irgb, input logic a260, input logic ac260,
                       input logic amid, input logic shortf, input logic rst120);
    for (int j = 0; j < 19; j++) begin
      if (shortf && ys[j] >= 200) break;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk9MHz); #1;
        if (j == 0 && i == 0) begin
          cur_bm = bm; inj_en = ie; inj_x = ix; inj_y = iy; inj_rgb = irgb;
        end
        vc    = 10'(xs[i]);
        lc    = 9'(ys[j]);
        arm   = (i == 0) && ((a260 && ys[j] == 260) || (amid && ys[j] == 120));
        arm_c = (i == 0) && ac260 && ys[j] == 260;
        reset = (i == 0) && rst120 && ys[j] == 120;
        if (ys[j] == 250 && i == 0) t250 = cyc;
        @(negedge clk9MHz);
        if (ys[j] == 120 && i == 2) begin busy_mid = busy1; bits_mid = bits1; err_mid = err1; end
        if (ys[j] == 250 && i == 10) busy_end = busy1;
      end
    end
  endtask

  task automatic run_vec(input string nm, input logic [24:0] bm, input logic ie, input int ix,
                         input int iy, input logic [23:0] irgb, input logic amid,
                         input logic [24:0] eb, input logic ee);
    int n0, m0;
    n0 = nval; m0 = nval0;
    frame(bm, ie, ix, iy, irgb, 1'b1, 1'b0, amid, 1'b0, 1'b0);
    chk($sformatf("%s pulses", nm), 32'(nval - n0), 32'd1);
    chk($sformatf("%s bits", nm), 32'(bits_q), 32'(eb));
    chk($sformatf("%s error", nm), 32'(err_q), 32'(ee));
    chk($sformatf("%s latency", nm), 32'(tv - t250), 32'd2);
    chk($sformatf("%s busy mid", nm), 32'(busy_mid), 32'd1);
    chk($sformatf("%s busy end", nm), 32'(busy_end), 32'd0);
    chk($sformatf("%s pd0 pulses", nm), 32'(nval0 - m0), 32'd1);
    chk($sformatf("%s pd0 bits", nm), 32'(bits0_q), 32'(eb));
    chk($sformatf("%s pd0 error", nm), 32'(err0_q), 32'(ee));
    chk($sformatf("%s pd0 latency", nm), 32'(tv0 - t250), 32'd1);
  endtask

  typedef struct {
    logic [24:0] bm;
    logic        ie;
    int          ix, iy;
    logic [23:0] irgb;
    logic [24:0] eb;
    logic        ee;
  } vec_t;
  vec_t tbl[6];

  initial begin
    logic [24:0] rb, eb;
    logic        rie, ee, ramid;
    int          rix, riy, n0, c0;
    logic [23:0] rrgb;

    tbl[0] = '{25'h1555555, 1'b0, 0,   0,   24'h0,      25'h1555555, 1'b0};
    tbl[1] = '{25'h1FFFFFF, 1'b0, 0,   0,   24'h0,      25'h1FFFFFF, 1'b0};
    tbl[2] = '{25'h0000000, 1'b0, 0,   0,   24'h0,      25'h0000000, 1'b0};
    tbl[3] = '{25'h0F0F0F0, 1'b1, 150, 120, 24'hFF80FF, 25'h0F0F0F0, 1'b1};
    tbl[4] = '{25'h1000001, 1'b1, 10,  5,   24'hFFFFFF, 25'h1000001, 1'b1};
    tbl[5] = '{25'h1000001, 1'b0, 0,   0,   24'h0,      25'h1000001, 1'b0};

    reset = 1'b1; arm = 1'b0; arm_c = 1'b0; vc = '0; lc = '0;
    cur_bm = '0; inj_en = 1'b0; inj_x = 0; inj_y = 0; inj_rgb = '0;
    repeat (2) @(posedge clk9MHz);
    #1 reset = 1'b0;
    @(negedge clk9MHz);
    chk("reset bits", 32'(bits1), 32'd0);
    chk("reset valid", 32'(val1), 32'd0);
    chk("reset busy", 32'(busy1), 32'd0);
    chk("reset error", 32'(err1), 32'd0);
    repeat (1000) @(posedge clk9MHz);
    @(negedge clk9MHz);
    chk("idle bits", 32'(bits1), 32'd0);
    chk("idle busy", 32'(busy1), 32'd0);
    chk("idle error", 32'(err1), 32'd0);
    chk("idle pulses", 32'(nval + nval0), 32'd0);

    frame('0, 1'b0, 0, 0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int v = 0; v < 6; v++)
      run_vec($sformatf("tbl%0d", v), tbl[v].bm, tbl[v].ie, tbl[v].ix, tbl[v].iy,
              tbl[v].irgb, 1'b0, tbl[v].eb, tbl[v].ee);

    for (int v = 0; v < 16; v++) begin
      rb    = 25'($urandom);
      rie   = 1'($urandom_range(0, 1));
      rix   = xs[$urandom_range(0, 19)];
      riy   = ys[$urandom_range(0, 15)];
      ramid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0:       rrgb = 24'hFFFFFF;
        1:       rrgb = 24'h000000;
        default: rrgb = 24'($urandom);
      endcase
      model(rb, rie, rix, riy, rrgb, 1'b0, eb, ee);
      run_vec($sformatf("rnd%0d", v), rb, rie, rix, riy, rrgb, ramid, eb, ee);
    end

    // Short frame: lines restart before 250, so row 4 is never seen.
    n0 = nval;
    frame(25'h1555555, 1'b0, 0, 0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    frame('0, 1'b0, 0, 0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("short pulses", 32'(nval - n0), 32'd1);
    chk("short bits", 32'(bits_q), 32'h1555540);
    chk("short error", 32'(err_q), 32'd1);

    // Reset mid-capture aborts the frame; re-arm then captures normally.
    n0 = nval;
    frame(25'h1555555, 1'b0, 0, 0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst pulses", 32'(nval - n0), 32'd0);
    chk("rst busy", 32'(busy_mid), 32'd0);
    chk("rst bits", 32'(bits_mid), 32'd0);
    chk("rst error", 32'(err_mid), 32'd0);
    run_vec("post-rst", 25'h1555555, 1'b0, 0, 0, '0, 1'b0, 25'h1555555, 1'b0);

    // Continuous mode: one arm, two consecutive captures.
    frame('0, 1'b0, 0, 0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    c0 = cbits.size();
    frame(25'h1FFFFFF, 1'b0, 0, 0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    frame(25'h0000000, 1'b0, 0, 0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("cont pulses", 32'(cbits.size() - c0), 32'd2);
    if (cbits.size() >= c0 + 2) begin
      chk("cont bits a", 32'(cbits[c0]), 32'h1FFFFFF);
      chk("cont error a", 32'(cerr[c0]), 32'd0);
      chk("cont bits b", 32'(cbits[c0 + 1]), 32'd0);
      chk("cont error b", 32'(cerr[c0 + 1]), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
